// File: rtl/grey_rgb_pkg.sv
// grey_rgb_pkg: shared mode encoding, width-scaling helper and frame counter width
package grey_rgb_pkg;
    typedef enum logic [1:0] {MODE_REPL, MODE_INV, MODE_THR, MODE_LUT} mode_t;
    localparam int FRAME_CNT_W = 24;
    // Scale an in_w-bit value to ch_w bits (both 1..8), result right-aligned.
    // Output bit i (from the MSB) takes input bit i mod in_w (from the MSB): this
    // repeats v MSB-first when widening and keeps the MSBs when narrowing.
    function automatic logic [7:0] scale(input logic [7:0] v, input int in_w, input int ch_w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i < ch_w) r[3'(ch_w-1-i)] = v[3'(in_w-1-(i%in_w))];
        return r;
    endfunction
endpackage

// File: rtl/grey_lut.sv
// grey_lut: pseudo-colour register file, reset to the replicate mapping
// Ports: clk, rst (sync, active-high); we/addr/wdata write port; raddr/rdata combinational read
module grey_lut import grey_rgb_pkg::*; #(
    parameter int IN_W   = 4,
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IN_W-1:0]          addr,
    input  logic [NUM_CH*CH_W-1:0]   wdata,
    input  logic [IN_W-1:0]          raddr,
    output logic [NUM_CH*CH_W-1:0]   rdata
);
    logic [NUM_CH*CH_W-1:0] mem [2**IN_W];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IN_W; i++)
                mem[i] <= {NUM_CH{CH_W'(scale(8'(i), IN_W, CH_W))}};
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/grey_to_rgb_stream.sv
// grey_to_rgb_stream: pipelined grey -> NUM_CH-channel expander with skid buffer
// Ports: clk, rst (sync, active-high); in_valid/in_ready/pixel_in/in_sof/in_eol input stream;
//   mode/thresh per-frame settings (taken on accepted sof); out_valid/out_ready/pixel_out/
//   out_sof/out_eol output stream; frame_pixels previous frame size; lut_we/lut_addr/lut_wdata
//   LUT write port. Macro PSEUDO_COLOUR_EN builds the LUT; otherwise mode 3 acts as replicate.
module grey_to_rgb_stream import grey_rgb_pkg::*; #(
    parameter int IN_W   = 4,
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          pixel_in,
    input  logic                     in_sof,
    input  logic                     in_eol,
    input  logic [1:0]               mode,
    input  logic [IN_W-1:0]          thresh,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   pixel_out,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic [FRAME_CNT_W-1:0]   frame_pixels,
    input  logic                     lut_we,
    input  logic [IN_W-1:0]          lut_addr,
    input  logic [NUM_CH*CH_W-1:0]   lut_wdata
);
    localparam int OW = NUM_CH*CH_W;
    mode_t                  mode_r, mode_e;
    logic [IN_W-1:0]        thr_r, thr_e, pix_n;
    logic [CH_W-1:0]        rep_ch, inv_ch;
    logic [OW-1:0]          pix, lut_rdata, skid_pix;
    logic                   skid_sof, skid_eol, skid_full, skid_nxt, acc, ld;
    logic [FRAME_CNT_W-1:0] cnt;

`ifdef PSEUDO_COLOUR_EN
    grey_lut #(.IN_W(IN_W), .CH_W(CH_W), .NUM_CH(NUM_CH)) u_lut (
        .clk(clk), .rst(rst), .we(lut_we), .addr(lut_addr), .wdata(lut_wdata),
        .raddr(pixel_in), .rdata(lut_rdata)
    );
`else
    wire unused_lut = ^{lut_we, lut_addr, lut_wdata};
    assign lut_rdata = {NUM_CH{rep_ch}};
`endif

    assign acc = in_valid && in_ready;
    // Output register can take a new beat when empty or being drained this cycle.
    assign ld = !out_valid || out_ready;
    // A full skid never coexists with an accept because in_ready is low then.
    assign skid_nxt = ld ? 1'b0 : (skid_full || acc);

    always_comb begin
        mode_e = in_sof ? mode_t'(mode) : mode_r;
        thr_e  = in_sof ? thresh : thr_r;
        pix_n  = ~pixel_in;
        rep_ch = CH_W'(scale(8'(pixel_in), IN_W, CH_W));
        inv_ch = CH_W'(scale(8'(pix_n), IN_W, CH_W));
        pix    = mode_e == MODE_INV ? {NUM_CH{inv_ch}} :
                 mode_e == MODE_THR ? (pixel_in >= thr_e ? '1 : '0) :
                 mode_e == MODE_LUT ? lut_rdata : {NUM_CH{rep_ch}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            in_ready     <= 1'b0;
            skid_full    <= 1'b0;
            pixel_out    <= '0;
            out_sof      <= 1'b0;
            out_eol      <= 1'b0;
            skid_pix     <= '0;
            skid_sof     <= 1'b0;
            skid_eol     <= 1'b0;
            mode_r       <= MODE_REPL;
            thr_r        <= '0;
            cnt          <= '0;
            frame_pixels <= '0;
        end else begin
            in_ready  <= !skid_nxt;
            skid_full <= skid_nxt;
            if (ld) begin
                out_valid <= skid_full || acc;
                if (skid_full)
                    {pixel_out, out_sof, out_eol} <= {skid_pix, skid_sof, skid_eol};
                else if (acc)
                    {pixel_out, out_sof, out_eol} <= {pix, in_sof, in_eol};
            end else if (acc) begin
                {skid_pix, skid_sof, skid_eol} <= {pix, in_sof, in_eol};
            end
            if (acc && in_sof) begin
                mode_r       <= mode_e;
                thr_r        <= thresh;
                frame_pixels <= cnt;
                cnt          <= FRAME_CNT_W'(1);
            end else if (acc && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/grey_to_rgb_stream.md
# grey_to_rgb_stream

Parametrised, pipelined successor to the combinational grey expander. Takes a stream of IN_W-bit grey pixels with frame sideband and emits NUM_CH channels of CH_W bits per pixel, under full valid/ready backpressure. It sits between the convolution output and the display/RGB packer. It adds per-frame mode selection (replicate, invert, threshold, optional pseudo-colour LUT) and a per-frame pixel count.

## Interface
- IN_W, 4: grey input width (1..8)
- CH_W, 4: output width per channel (1..8)
- NUM_CH, 3: output channel count (1..4); channel 0 is the MSB field of pixel_out
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- pixel_in  in  IN_W  grey pixel
- in_sof  in  1  first pixel of frame
- in_eol  in  1  last pixel of line
- mode  in  2  0 replicate, 1 invert, 2 threshold, 3 pseudo-colour; sampled only on an accepted in_sof beat
- thresh  in  IN_W  threshold level; sampled with mode
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- pixel_out  out  NUM_CH*CH_W  expanded pixel
- out_sof, out_eol  out  1 each  sideband, aligned with pixel_out
- frame_pixels  out  24  pixels accepted in the previous frame
- lut_we  in  1  LUT write strobe
- lut_addr  in  IN_W  LUT entry index
- lut_wdata  in  NUM_CH*CH_W  LUT entry value

## Operation
- Active mode/thresh registers load from mode/thresh on an accepted beat with in_sof=1. That beat and all later beats use the new values. Reset value: mode 0, thresh 0.
- Width scaling of value v (IN_W to CH_W):
  - CH_W ≥ IN_W: MSB-first bit replication, repeating v until CH_W bits are filled. 4→8 maps 0xA to 0xAA.
  - CH_W < IN_W: take the CH_W MSBs.
- Replicate: every channel = scale(p).
- Invert: every channel = scale(~p).
- Threshold: every channel = all-ones if p ≥ thresh, else 0.
- Pseudo-colour: pixel_out = LUT[p].
- frame_pixels:
  - An internal 24-bit counter increments on each accepted beat.
  - On an accepted in_sof beat, frame_pixels ← counter value, and the counter ← 1.
  - The counter saturates at 0xFFFFFF.
  - The first in_sof after reset writes 0.
- Pipeline:
  - One output register, plus a one-entry skid register.
  - in_ready is registered and equals !skid_full.
  - If the output register is stalled (out_valid && !out_ready) and a beat is accepted, that beat goes to the skid register.
  - When the output register drains, the skid entry moves into it on the same cycle.
  - Order is preserved; no beat is dropped or duplicated.
- Reset: out_valid 0, in_ready 0 during reset and 1 the cycle after, skid empty, pixel_out 0, out_sof/out_eol 0, frame_pixels 0, counter 0. Reset mid-frame discards all in-flight beats.

## Timing
- Latency: accept at cycle N gives out_valid at N+1 when no stall is present.
- Throughput: one pixel per clock with out_ready held high.
- Stall: pixel_out and sideband hold stable while out_valid && !out_ready.
- in_ready falls the cycle after the skid fills, and rises the cycle after the skid drains.
- A simultaneous accept and drain with an empty skid passes straight to the output register.
- A LUT write at cycle N affects beats accepted at N+1 onward. A write to the entry used by a beat accepted on the same cycle N returns the old value.

## Configuration
- PSEUDO_COLOUR_EN defined: LUT of 2^IN_W entries is built; mode 3 uses it.
- PSEUDO_COLOUR_EN undefined: no LUT storage; mode 3 behaves as mode 0; lut_* ports are present but ignored.

## Structure
- Shared package grey_rgb_pkg: mode enum (MODE_REPL, MODE_INV, MODE_THR, MODE_LUT), the scale function, and the FRAME_CNT_W = 24 constant.
- Sub-module grey_lut: synchronous-reset register file. Reset loads entry i = replicate mapping of i. One write port and one combinational read port.

## Test plan
- Reset release, IN_W=4, CH_W=4, mode 0: pixel 0xA with sof → pixel_out 0xAAA one cycle later; out_sof=1.
- CH_W=8, mode 1: pixel 0x3 → each channel 0xCC; CH_W=2, mode 0: pixel 0xB → 0b10 per channel.
- Threshold, thresh 0x8: pixels 0x7, 0x8, 0xF → 0x000, 0xFFF, 0xFFF.
- Backpressure: stream 0..15, out_ready toggled in a 3-low/2-high pattern → output is exactly 0..15 in order; in_ready drops only while the skid is full; pixel_out is stable during stalls.
- Frame count: 100 beats, then sof → frame_pixels=100. Reset mid-frame → out_valid=0 and frame_pixels=0.
- With PSEUDO_COLOUR_EN, write LUT[5]=0xF00 and select mode 3 on sof; pixel 5 → 0xF00. Without the macro, the same stimulus → 0x555.
